lrclk_rate_detect: RTL and testbench

LRCLK_RATE_DETECT -- requirements
Module: lrclk_rate_detect

---
 rtl/audio_clk_pkg.sv | 41 ++++
 rtl/lrclk_rate_detect_if.sv | 22 ++
 rtl/rate_classify.sv | 25 ++
 rtl/lrclk_rate_detect.sv | 141 ++++++++++++++
 tb/tb_lrclk_rate_detect.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_clk_pkg.sv
// Shared audio-clock constants: rate codes, LRCLK period windows (in 100 MHz
// clk cycles) and the rate-detector FSM state type.
package audio_clk_pkg;

  localparam int PERIOD_W = 16;
  localparam int RATE_W   = 3;

  localparam logic [RATE_W-1:0] RATE_NONE    = 3'd0;
  localparam logic [RATE_W-1:0] RATE_44K1    = 3'd1;
  localparam logic [RATE_W-1:0] RATE_48K     = 3'd2;
  localparam logic [RATE_W-1:0] RATE_88K2    = 3'd3;
  localparam logic [RATE_W-1:0] RATE_96K     = 3'd4;
  localparam logic [RATE_W-1:0] RATE_176K4   = 3'd5;
  localparam logic [RATE_W-1:0] RATE_192K    = 3'd6;
  localparam logic [RATE_W-1:0] RATE_UNKNOWN = 3'd7;

  // Inclusive bounds; each window brackets the nominal period with margin for jitter.
  localparam logic [PERIOD_W-1:0] WIN_192K_LO  = 16'd500;
  localparam logic [PERIOD_W-1:0] WIN_192K_HI  = 16'd540;
  localparam logic [PERIOD_W-1:0] WIN_176K4_LO = 16'd550;
  localparam logic [PERIOD_W-1:0] WIN_176K4_HI = 16'd590;
  localparam logic [PERIOD_W-1:0] WIN_96K_LO   = 16'd1020;
  localparam logic [PERIOD_W-1:0] WIN_96K_HI   = 16'd1060;
  localparam logic [PERIOD_W-1:0] WIN_88K2_LO  = 16'd1110;
  localparam logic [PERIOD_W-1:0] WIN_88K2_HI  = 16'd1160;
  localparam logic [PERIOD_W-1:0] WIN_48K_LO   = 16'd2060;
  localparam logic [PERIOD_W-1:0] WIN_48K_HI   = 16'd2110;
  localparam logic [PERIOD_W-1:0] WIN_44K1_LO  = 16'd2240;
  localparam logic [PERIOD_W-1:0] WIN_44K1_HI  = 16'd2300;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQUIRE,
    ST_MEASURE
  } det_state_e;

  function automatic logic code_is_valid(input logic [RATE_W-1:0] code);
    return (code != RATE_NONE) && (code != RATE_UNKNOWN);
  endfunction

endpackage

// File: rtl/lrclk_rate_detect_if.sv
// Signal bundle between an LRCLK source/consumer and the rate detector.
interface lrclk_rate_detect_if;
  import audio_clk_pkg::*;

  logic                lrclk_sync;
  logic                enable_sync;
  logic [RATE_W-1:0]   rate_code;
  logic                rate_valid;
  logic [PERIOD_W-1:0] period;
  logic                rate_change;
  logic                lrclk_lost;

  modport master (
    output lrclk_sync, enable_sync,
    input  rate_code, rate_valid, period, rate_change, lrclk_lost
  );

  modport slave (
    input  lrclk_sync, enable_sync,
    output rate_code, rate_valid, period, rate_change, lrclk_lost
  );
endinterface

// File: rtl/rate_classify.sv
// Combinational lookup from a measured LRCLK period to an audio rate code.
module rate_classify
  import audio_clk_pkg::*;
(
  input  logic [PERIOD_W-1:0] period_i,
  output logic [RATE_W-1:0]   code_o
);

  function automatic logic in_win(input logic [PERIOD_W-1:0] p,
                                  input logic [PERIOD_W-1:0] lo,
                                  input logic [PERIOD_W-1:0] hi);
    return (p >= lo) && (p <= hi);
  endfunction

  always_comb begin
    code_o = RATE_UNKNOWN;
    if      (in_win(period_i, WIN_192K_LO,  WIN_192K_HI))  code_o = RATE_192K;
    else if (in_win(period_i, WIN_176K4_LO, WIN_176K4_HI)) code_o = RATE_176K4;
    else if (in_win(period_i, WIN_96K_LO,   WIN_96K_HI))   code_o = RATE_96K;
    else if (in_win(period_i, WIN_88K2_LO,  WIN_88K2_HI))  code_o = RATE_88K2;
    else if (in_win(period_i, WIN_48K_LO,   WIN_48K_HI))   code_o = RATE_48K;
    else if (in_win(period_i, WIN_44K1_LO,  WIN_44K1_HI))  code_o = RATE_44K1;
  end

endmodule

// File: rtl/lrclk_rate_detect.sv
// Measures the LRCLK period in clk cycles, classifies it, and reports a rate
// once STABLE_N consecutive measurements agree; flags a lost LRCLK after TIMEOUT.
module lrclk_rate_detect
  import audio_clk_pkg::*;
#(
  parameter int unsigned STABLE_N = 4,
  parameter int unsigned TIMEOUT  = 8192
) (
  input  logic                clk_clkin,
  input  logic                reset_n,
  input  logic                lrclk_sync,
  input  logic                enable_sync,
  output logic [RATE_W-1:0]   rate_code,
  output logic                rate_valid,
  output logic [PERIOD_W-1:0] period,
  output logic                rate_change,
  output logic                lrclk_lost
);

  localparam int unsigned         STAB_W      = $clog2(STABLE_N + 1);
  localparam logic [STAB_W-1:0]   STAB_MAX    = STAB_W'(STABLE_N);
  localparam logic [STAB_W-1:0]   STAB_ONE    = STAB_W'(1);
  localparam logic [PERIOD_W-1:0] CNT_MAX     = '1;
  localparam logic [PERIOD_W-1:0] CNT_TIMEOUT = PERIOD_W'(TIMEOUT - 1);

  det_state_e          state_q, state_d;
  logic                lrclk_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [RATE_W-1:0]   cand_q, cand_d;
  logic [STAB_W-1:0]   stab_q, stab_d;
  logic [RATE_W-1:0]   code_q, code_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                change_q, change_d;
  logic                lost_q, lost_d;

  logic                edge_seen;
  logic                timeout_hit;
  logic [PERIOD_W-1:0] meas;
  logic [RATE_W-1:0]   meas_code;

  assign edge_seen   = lrclk_sync & ~lrclk_d;
  assign timeout_hit = (cnt_q == CNT_TIMEOUT);
  assign meas        = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 16'd1;

  rate_classify u_classify (
    .period_i (meas),
    .code_o   (meas_code)
  );

  // NOTE: every variable gets a default before any branch so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 16'd1;
    cand_d   = cand_q;
    stab_d   = stab_q;
    code_d   = code_q;
    period_d = period_q;
    change_d = 1'b0;
    lost_d   = lost_q;

    if (!enable_sync) begin
      // Disabled: everything returns to a clean slate, silently (no rate_change).
      state_d  = ST_IDLE;
      cnt_d    = '0;
      cand_d   = RATE_NONE;
      stab_d   = '0;
      code_d   = RATE_NONE;
      period_d = '0;
      lost_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQUIRE;
          cnt_d   = '0;
        end
        ST_ACQUIRE, ST_MEASURE: begin
          if (edge_seen) begin
            state_d = ST_MEASURE;
            cnt_d   = '0;
            lost_d  = 1'b0;
            // The first edge after acquiring only starts the period count.
            if (state_q == ST_MEASURE) begin
              period_d = meas;
              cand_d   = meas_code;
              if (meas_code == cand_q)
                stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + STAB_ONE;
              else
                stab_d = STAB_ONE;
              if ((stab_d == STAB_MAX) && (meas_code != code_q)) begin
                code_d   = meas_code;
                change_d = 1'b1;
              end
            end
          end else if (timeout_hit) begin
            state_d  = ST_ACQUIRE;
            lost_d   = 1'b1;
            change_d = (code_q != RATE_NONE);
            code_d   = RATE_NONE;
            cand_d   = RATE_NONE;
            stab_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_clkin or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      lrclk_d  <= 1'b0;
      cnt_q    <= '0;
      cand_q   <= RATE_NONE;
      stab_q   <= '0;
      code_q   <= RATE_NONE;
      period_q <= '0;
      change_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lrclk_d  <= lrclk_sync;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      stab_q   <= stab_d;
      code_q   <= code_d;
      period_q <= period_d;
      change_q <= change_d;
      lost_q   <= lost_d;
    end
  end

  assign rate_code   = code_q;
  assign rate_valid  = code_is_valid(code_q);
  assign period      = period_q;
  assign rate_change = change_q;
  assign lrclk_lost  = lost_q;

endmodule

// File: tb/tb_lrclk_rate_detect.sv
// Self-checking bench for lrclk_rate_detect: directed scenarios plus random
// LRCLK periods, checked every cycle against a behavioural rate model.
module tb_lrclk_rate_detect;
  import audio_clk_pkg::*;

  localparam int STABLE_N = 4;
  localparam int TIMEOUT  = 8192;

  logic clk_clkin = 1'b0;
  logic reset_n   = 1'b0;

  lrclk_rate_detect_if dif ();

  lrclk_rate_detect #(.STABLE_N(STABLE_N), .TIMEOUT(TIMEOUT)) dut (
    .clk_clkin   (clk_clkin),
    .reset_n     (reset_n),
    .lrclk_sync  (dif.lrclk_sync),
    .enable_sync (dif.enable_sync),
    .rate_code   (dif.rate_code),
    .rate_valid  (dif.rate_valid),
    .period      (dif.period),
    .rate_change (dif.rate_change),
    .lrclk_lost  (dif.lrclk_lost)
  );

  always #5 clk_clkin = ~clk_clkin;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Behavioural model: expected outputs after the most recent clock edge.
  int  m_phase;   // 0 disabled, 1 waiting for first edge, 2 measuring
  int  m_cnt;     // cycles since the last LRCLK rising edge
  bit  m_lr_d;
  int  m_code;
  int  m_period;
  bit  m_change;
  bit  m_lost;
  int  hist[$];   // classifications since the last clear, newest last

  // Stimulus-side bookkeeping
  bit  tb_prev_lr = 1'b0;
  bit  cur_en, cur_lr;
  int  edge_q[$];
  int  last_edge_cyc = -1;
  int  pulse_cnt, first_pulse_cyc, lost_rise_cyc;
  bit  prev_lost = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int tb_classify(input int p);
    int lo[6];
    int hi[6];
    lo = '{2240, 2060, 1110, 1020, 550, 500};
    hi = '{2300, 2110, 1160, 1060, 590, 540};
    for (int i = 0; i < 6; i++)
      if (p >= lo[i] && p <= hi[i]) return i + 1;
    return 7;
  endfunction

  function automatic void m_reset();
    m_phase = 0; m_cnt = 0; m_lr_d = 1'b0; m_code = 0;
    m_period = 0; m_change = 1'b0; m_lost = 1'b0;
    hist.delete();
  endfunction

  function automatic void m_step(input bit en, input bit lr);
    bit edge_now;
    bit same;
    int p;
    edge_now = lr && !m_lr_d;
    m_lr_d   = lr;
    m_change = 1'b0;
    if (!en) begin
      m_phase = 0; m_cnt = 0; hist.delete();
      m_code = 0; m_period = 0; m_lost = 1'b0;
    end else if (m_phase == 0) begin
      m_phase = 1; m_cnt = 0;
    end else if (edge_now) begin
      if (m_phase == 2) begin
        p = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
        m_period = p;
        hist.push_back(tb_classify(p));
        if (hist.size() > STABLE_N) void'(hist.pop_front());
        same = (hist.size() == STABLE_N);
        foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
        if (same && hist[0] != m_code) begin
          m_code = hist[0]; m_change = 1'b1;
        end
      end
      m_phase = 2; m_cnt = 0; m_lost = 1'b0;
    end else begin
      if (m_cnt == TIMEOUT - 1) begin
        m_lost = 1'b1; m_change = (m_code != 0); m_code = 0;
        hist.delete(); m_phase = 1;
      end
      if (m_cnt < 65535) m_cnt++;
    end
  endfunction

  // One clock cycle: compare outputs, then drive this cycle's inputs.
  task automatic tick(input bit en, input bit lr);
    @(negedge clk_clkin);
    cyc++;
    check("rate_code",   dif.rate_code,   m_code);
    check("rate_valid",  dif.rate_valid,  (m_code >= 1 && m_code <= 6));
    check("period",      dif.period,      m_period);
    check("rate_change", dif.rate_change, m_change);
    check("lrclk_lost",  dif.lrclk_lost,  m_lost);
    if (dif.rate_change === 1'b1) begin
      pulse_cnt++;
      if (first_pulse_cyc < 0) first_pulse_cyc = cyc;
    end
    if (dif.lrclk_lost === 1'b1 && !prev_lost) lost_rise_cyc = cyc;
    prev_lost = (dif.lrclk_lost === 1'b1);
    dif.enable_sync = en;
    dif.lrclk_sync  = lr;
    if (lr && !tb_prev_lr) begin
      edge_q.push_back(cyc);
      last_edge_cyc = cyc;
    end
    tb_prev_lr = lr; cur_en = en; cur_lr = lr;
    if (reset_n) m_step(en, lr);
    else         m_reset();
  endtask

  task automatic hold(input int n, input bit en, input bit lr);
    repeat (n) tick(en, lr);
  endtask

  task automatic run_period(input int p, input int n_edges);
    for (int e = 0; e < n_edges; e++)
      for (int i = 0; i < p; i++) tick(1'b1, i < p / 2);
  endtask

  task automatic mark();
    pulse_cnt = 0; first_pulse_cyc = -1; lost_rise_cyc = -1;
    edge_q.delete();
  endtask

  task automatic restart_enabled();
    hold(3, 1'b0, 1'b0);
    hold(2, 1'b1, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p, n, w;
    int wlo[4];
    int whi[4];
    wlo = '{500, 550, 1020, 1110};
    whi = '{540, 590, 1060, 1160};

    dif.enable_sync = 1'b0;
    dif.lrclk_sync  = 1'b0;
    m_reset();
    mark();

    // Reset state
    hold(3, 1'b0, 1'b0);
    check("rst_code",   dif.rate_code,  0);
    check("rst_period", dif.period,     0);
    check("rst_lost",   dif.lrclk_lost, 0);
    reset_n = 1'b1;
    m_step(cur_en, cur_lr);

    // 48k lock: acquire edge + 4 measurements
    hold(4, 1'b1, 1'b0);
    mark();
    run_period(2083, 5);
    check("lock48_code",      dif.rate_code,  2);
    check("lock48_valid",     dif.rate_valid, 1);
    check("lock48_period",    dif.period,     2083);
    check("lock48_pulses",    pulse_cnt,      1);
    check("lock48_pulse_cyc", first_pulse_cyc, edge_q[4] + 1);

    // Switch to 96k: first new edge still measures 2083
    mark();
    run_period(1042, 5);
    check("sw96_code",      dif.rate_code, 4);
    check("sw96_period",    dif.period,    1042);
    check("sw96_pulses",    pulse_cnt,     1);
    check("sw96_pulse_cyc", first_pulse_cyc, edge_q[4] + 1);

    // Asynchronous reset mid-lock, released with LRCLK already high
    for (int i = 0; i < 200; i++) tick(1'b1, i < 100);
    #2 reset_n = 1'b0;
    #1;
    check("arst_code",   dif.rate_code,   0);
    check("arst_valid",  dif.rate_valid,  0);
    check("arst_period", dif.period,      0);
    check("arst_change", dif.rate_change, 0);
    check("arst_lost",   dif.lrclk_lost,  0);
    m_reset();
    hold(3, 1'b1, 1'b1);
    reset_n = 1'b1;
    m_step(cur_en, cur_lr);
    run_period(520, 6);
    check("lock192_code", dif.rate_code, 6);

    // Disable mid-lock: outputs clear with no rate_change
    mark();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("dis_code",   dif.rate_code,  0);
    check("dis_valid",  dif.rate_valid, 0);
    check("dis_period", dif.period,     0);
    check("dis_pulses", pulse_cnt,      0);

    // Timeout while locked at 48k, then restart
    hold(2, 1'b1, 1'b0);
    run_period(2083, 5);
    check("pre_to_code", dif.rate_code, 2);
    mark();
    p = last_edge_cyc;
    hold(8300, 1'b1, 1'b0);
    check("to_latency",   lost_rise_cyc - (p + 1), TIMEOUT);
    check("to_pulses",    pulse_cnt,       1);
    check("to_pulse_cyc", first_pulse_cyc, lost_rise_cyc);
    check("to_code",      dif.rate_code,   0);
    check("to_lost",      dif.lrclk_lost,  1);
    run_period(2083, 1);
    check("restart_lost", dif.lrclk_lost, 0);

    // Glitch rejection: 2083, 2083, 1200, 2083, 2083
    restart_enabled();
    mark();
    run_period(2083, 2);
    run_period(1200, 1);
    run_period(2083, 3);
    check("glitch_pulses", pulse_cnt,     0);
    check("glitch_code",   dif.rate_code, 0);

    // Unknown rate
    restart_enabled();
    mark();
    run_period(3000, 5);
    check("unk_code",   dif.rate_code,  7);
    check("unk_valid",  dif.rate_valid, 0);
    check("unk_period", dif.period,     3000);
    check("unk_pulses", pulse_cnt,      1);

    // Window boundary: 540 is 192k, 541 is unknown
    restart_enabled();
    run_period(540, 5);
    check("edge540_code", dif.rate_code, 6);
    mark();
    run_period(541, 5);
    check("edge541_code",   dif.rate_code, 7);
    check("edge541_pulses", pulse_cnt,     1);

    // Random periods around the high-rate windows, with occasional disables
    repeat (5) begin
      if ($urandom_range(3, 0) == 0) hold($urandom_range(3, 1), 1'b0, 1'b0);
      w = $urandom_range(3, 0);
      if ($urandom_range(4, 0) == 0) p = $urandom_range(1300, 400);
      else                           p = $urandom_range(whi[w] + 6, wlo[w] - 6);
      n = $urandom_range(4, 1);
      run_period(p, n);
    end
    hold(5, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
